// File: rtl/bullet_scheduler_pkg.sv
// bullet_scheduler_pkg
// Shared screen/sprite geometry for the bullet path, plus the frame-update
// FSM state type and the derived bullet spawn row.
package bullet_scheduler_pkg;

  localparam int HRES     = 640;
  localparam int VRES     = 480;
  localparam int PADDLE_W = 32;
  localparam int PADDLE_H = 8;
  localparam int BULLET_W = 4;
  localparam int BULLET_H = 8;

  // Bullets appear with their bottom edge resting on the paddle top.
  localparam int BULLET_SPAWN_Y = VRES - PADDLE_H - BULLET_H;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    SPAWN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/bullet_scheduler_free_slot_pick.sv
// free_slot_pick
// Combinational lowest-set-bit finder over a free-slot mask.
// Ports:
//   free  : N-bit mask, 1 = slot available
//   idx   : index of the lowest set bit (0 when none)
//   valid : at least one bit of free is set
module free_slot_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  free,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan high to low so the lowest set bit is the last to win.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bullet_scheduler.sv
// bullet_scheduler
// Owns a pool of N_SLOTS player bullets. Once per frame (fsync) it walks the
// slots one per cycle moving live bullets up by BULLET_SPEED and retiring
// those that leave the top, then spends one cycle spawning a pending shot
// into the lowest free slot subject to a frame cooldown.
// Ports:
//   pixel_clk, rst_n : clock, async active-low reset
//   fsync            : frame-start pulse
//   fire             : fire button level
//   player_x         : paddle left edge (signed), sampled in SPAWN only
//   hit              : per-slot kill pulses
//   slot_active/x/y  : slot state, x/y packed 12 bits per slot
//   busy             : frame update in progress
//   fire_ack         : one-cycle pulse per spawned bullet
//   overrun          : sticky, fsync seen while busy
// Build option: BULLET_AUTOFIRE_EN makes fire level-sensitive (autofire).
module bullet_scheduler
  import bullet_scheduler_pkg::*;
#(
  parameter int N_SLOTS         = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int BULLET_SPEED    = 4
) (
  input  logic                    pixel_clk,
  input  logic                    rst_n,
  input  logic                    fsync,
  input  logic                    fire,
  input  logic signed [11:0]      player_x,
  input  logic [N_SLOTS-1:0]      hit,
  output logic [N_SLOTS-1:0]      slot_active,
  output logic [N_SLOTS*12-1:0]   slot_x,
  output logic [N_SLOTS*12-1:0]   slot_y,
  output logic                    busy,
  output logic                    fire_ack,
  output logic                    overrun
);

  localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [IW-1:0]       LAST_IDX  = IW'(N_SLOTS - 1);
  localparam logic signed [12:0]  X_OFS     = 13'((PADDLE_W - BULLET_W) / 2);
  localparam logic signed [12:0]  X_MAX     = 13'(HRES - BULLET_W);

  sched_state_t    state, state_nxt;
  logic [IW-1:0]   idx;
  logic [7:0]      cooldown;
  logic            pending;
  logic            fire_q;
  logic            fire_set;
  logic            spawn_en;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic signed [12:0] x_sum;
  logic [11:0]     spawn_x;

  assign busy = (state != IDLE);

`ifdef BULLET_AUTOFIRE_EN
  assign fire_set = fire;
`else
  assign fire_set = fire & ~fire_q;
`endif

  // Picks against the registered active mask, so a slot hit during SPAWN
  // still looks occupied this cycle.
  free_slot_pick #(.N(N_SLOTS), .IW(IW)) u_pick (
    .free  (~slot_active),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign spawn_en = (state == SPAWN) && pending && (cooldown == 8'd0) && pick_valid;

  // Sign-extend before the offset so a far-right paddle cannot wrap negative.
  assign x_sum = $signed({player_x[11], player_x}) + X_OFS;

  always_comb begin
    if (x_sum < 13'sd0)      spawn_x = '0;
    else if (x_sum > X_MAX)  spawn_x = X_MAX[11:0];
    else                     spawn_x = x_sum[11:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fsync) state_nxt = MOVE;
      MOVE:    if (idx == LAST_IDX) state_nxt = SPAWN;
      SPAWN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cooldown <= 8'd0;
      pending  <= 1'b0;
      fire_q   <= 1'b0;
      fire_ack <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fire_q   <= fire;
      fire_ack <= spawn_en;
      if (fsync && busy) overrun <= 1'b1;

      if (state == IDLE && fsync) idx <= '0;
      else if (state == MOVE)     idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;

      if (spawn_en)
        cooldown <= 8'(COOLDOWN_FRAMES);
      else if (state == IDLE && fsync && cooldown != 8'd0)
        cooldown <= cooldown - 8'd1;

      // SPAWN consumes the request; an edge landing in SPAWN re-arms it.
      if (state == SPAWN) pending <= fire_set;
      else                pending <= pending | fire_set;
    end
  end

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    logic        act_q;
    logic [11:0] x_q, y_q, y_new;
    logic        spawn_here, move_here;

    assign y_new      = y_q - 12'(BULLET_SPEED);
    assign spawn_here = spawn_en && (pick_idx == IW'(i));
    assign move_here  = (state == MOVE) && (idx == IW'(i)) && act_q;

    // A hit on a free slot being spawned refers to nothing, so spawn wins;
    // otherwise hit beats the move update.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
        act_q <= 1'b0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (spawn_here) begin
        act_q <= 1'b1;
        x_q   <= spawn_x;
        y_q   <= 12'(BULLET_SPAWN_Y);
      end else if (hit[i]) begin
        act_q <= 1'b0;
      end else if (move_here) begin
        if (y_new[11]) act_q <= 1'b0;
        else           y_q   <= y_new;
      end
    end

    assign slot_active[i]       = act_q;
    assign slot_x[12*i +: 12]   = x_q;
    assign slot_y[12*i +: 12]   = y_q;
  end

endmodule
